// File: rtl/csr_access_ctrl.sv
// CSR access controller: sequences one CSR instruction through read, modify and write of CSR storage.
// Optional macro CSR_COUNTERS_EN adds internal 64-bit mcycle/minstret counters served without storage access.
module csr_access_ctrl #(
  parameter int          XLEN        = 32,
  parameter int unsigned MHARTID_VAL = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [16:0]     req_params,
  input  logic [XLEN-1:0] req_operand,
  input  logic [1:0]      cur_priv,
  output logic            csr_rd_en,
  output logic [11:0]     csr_rd_addr,
  input  logic [XLEN-1:0] csr_rd_data,
  output logic            csr_wr_en,
  output logic [11:0]     csr_wr_addr,
  output logic [XLEN-1:0] csr_wr_data,
  input  logic            instret_inc,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_illegal
);

  typedef enum logic [1:0] {
    FUNC_NONE = 2'd0,
    FUNC_RW   = 2'd1,
    FUNC_RS   = 2'd2,
    FUNC_RC   = 2'd3
  } write_func_e;

  typedef struct packed {
    logic        read_enable;
    logic        write_enable;
    logic        input_select;
    write_func_e write_func;
    logic [11:0] addr;
  } csr_params_t;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e          state_q, state_d;
  csr_params_t     params_q, params_d;
  logic [XLEN-1:0] operand_q, operand_d;
  logic [1:0]      priv_q, priv_d;
  logic [XLEN-1:0] old_q, old_d;
  logic            illegal_q, illegal_d;

  csr_params_t     req_p;
  logic            req_illegal;
  logic            do_write;
  logic            internal_hit;
  logic [XLEN-1:0] internal_rdata;
  logic [XLEN-1:0] read_val;
  logic [XLEN-1:0] new_val;
  logic            unused_bits;

  assign req_p       = csr_params_t'(req_params);
  assign req_illegal = (cur_priv < req_p.addr[9:8]) ||
                       (req_p.write_enable && (req_p.addr[11:10] == 2'b11));
  assign do_write    = params_q.write_enable && (params_q.write_func != FUNC_NONE);
  assign unused_bits = ^{priv_q, params_q.input_select};

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic        ctr_wr;
  logic [31:0] wr_word;

  assign ctr_wr  = (state_q == WRITE) && do_write;
  assign wr_word = new_val[31:0];

  always_comb begin
    internal_hit   = 1'b1;
    internal_rdata = '0;
    case (params_q.addr)
      12'hF14:          internal_rdata = XLEN'(MHARTID_VAL);
      12'hB00, 12'hC00: internal_rdata = XLEN'(mcycle_q[31:0]);
      12'hB80, 12'hC80: internal_rdata = XLEN'(mcycle_q[63:32]);
      12'hB02, 12'hC02: internal_rdata = XLEN'(minstret_q[31:0]);
      12'hB82, 12'hC82: internal_rdata = XLEN'(minstret_q[63:32]);
      default:          internal_hit   = 1'b0;
    endcase
  end

  // A software write replaces the whole counter update for that cycle.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, instret_inc};
    if (ctr_wr) begin
      case (params_q.addr)
        12'hB00: mcycle_d   = {mcycle_q[63:32], wr_word};
        12'hB80: mcycle_d   = {wr_word, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], wr_word};
        12'hB82: minstret_d = {wr_word, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`else
  logic unused_instret;

  assign internal_hit   = (params_q.addr == 12'hF14);
  assign internal_rdata = XLEN'(MHARTID_VAL);
  assign unused_instret = instret_inc;
`endif

  // Without read_enable the old value is defined as zero for every function.
  assign read_val = !params_q.read_enable ? '0 :
                    internal_hit          ? internal_rdata : csr_rd_data;

  always_comb begin
    case (params_q.write_func)
      FUNC_RS: new_val = read_val | operand_q;
      FUNC_RC: new_val = read_val & ~operand_q;
      default: new_val = operand_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    params_d  = params_q;
    operand_d = operand_q;
    priv_d    = priv_q;
    old_d     = old_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          params_d  = req_p;
          operand_d = req_operand;
          priv_d    = cur_priv;
          old_d     = '0;
          illegal_d = req_illegal;
          state_d   = req_illegal ? RESP : READ;
        end
      end
      READ:  state_d = WRITE;
      WRITE: begin
        old_d   = read_val;
        state_d = RESP;
      end
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      params_q  <= '0;
      operand_q <= '0;
      priv_q    <= '0;
      old_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      params_q  <= params_d;
      operand_q <= operand_d;
      priv_q    <= priv_d;
      old_q     <= old_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs are gated by rst so they read zero during reset regardless of state.
  assign req_ready    = !rst && (state_q == IDLE);
  assign csr_rd_en    = !rst && (state_q == READ) && params_q.read_enable && !internal_hit;
  assign csr_rd_addr  = csr_rd_en ? params_q.addr : '0;
  assign csr_wr_en    = !rst && (state_q == WRITE) && do_write && !internal_hit;
  assign csr_wr_addr  = csr_wr_en ? params_q.addr : '0;
  assign csr_wr_data  = csr_wr_en ? new_val : '0;
  assign resp_valid   = !rst && (state_q == RESP);
  assign resp_rdata   = resp_valid ? old_q : '0;
  assign resp_illegal = resp_valid && illegal_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: a transaction-level model fills a per-cycle
// expectation timeline that one monitor compares against the DUT on every cycle.
module tb_csr_access_ctrl;

  localparam logic [1:0] F_NONE = 2'd0;
  localparam logic [1:0] F_RW   = 2'd1;
  localparam logic [1:0] F_RS   = 2'd2;
  localparam logic [1:0] F_RC   = 2'd3;
  localparam logic [1:0] P_U    = 2'd0;
  localparam logic [1:0] P_S    = 2'd1;
  localparam logic [1:0] P_M    = 2'd3;
  localparam logic [31:0] HARTID = 32'd7;
`ifdef CSR_COUNTERS_EN
  localparam bit COUNTERS = 1'b1;
`else
  localparam bit COUNTERS = 1'b0;
`endif

  typedef struct packed {
    logic        req_ready;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        illegal;
  } obs_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [16:0] req_params;
  logic [31:0] req_operand;
  logic [1:0]  cur_priv;
  logic        csr_rd_en;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic        csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        instret_inc;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_illegal;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   inc_until = -1;
  int   rd_count = 0;
  int   wr_count = 0;
  int   last_resp_cyc = 0;
  logic prev_rv = 1'b0;
  logic last_illegal = 1'b0;
  logic [31:0] last_wr_data = '0;
  logic [31:0] last_rdata = '0;

  obs_t        sched [int];
  logic [31:0] mem_wr [int];

  csr_access_ctrl #(
    .XLEN        (32),
    .MHARTID_VAL (7)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_params   (req_params),
    .req_operand  (req_operand),
    .cur_priv     (cur_priv),
    .csr_rd_en    (csr_rd_en),
    .csr_rd_addr  (csr_rd_addr),
    .csr_rd_data  (csr_rd_data),
    .csr_wr_en    (csr_wr_en),
    .csr_wr_addr  (csr_wr_addr),
    .csr_wr_data  (csr_wr_data),
    .instret_inc  (instret_inc),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_illegal (resp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Storage contents: a fixed pattern per address until something is written there.
  function automatic logic [31:0] mem_read(input logic [11:0] addr);
    if (mem_wr.exists(int'(addr))) return mem_wr[int'(addr)];
    if (addr == 12'h300) return 32'h0000_1800;
    return 32'h8000_0000 | {16'h0, addr, 4'h0};
  endfunction

  // CSR storage: read data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (csr_rd_en) csr_rd_data <= mem_read(csr_rd_addr);
    if (csr_wr_en) mem_wr[int'(csr_wr_addr)] = csr_wr_data;
  end

  // Monitor: compare every scheduled cycle, and record strobe/response history.
  initial begin
    obs_t act;
    obs_t exp;
    forever begin
      @(negedge clk);
      act.req_ready  = req_ready;
      act.rd_en      = csr_rd_en;
      act.rd_addr    = csr_rd_addr;
      act.wr_en      = csr_wr_en;
      act.wr_addr    = csr_wr_addr;
      act.wr_data    = csr_wr_data;
      act.resp_valid = resp_valid;
      act.rdata      = resp_rdata;
      act.illegal    = resp_illegal;
      if (sched.exists(cyc)) begin
        exp = sched[cyc];
        checks++;
        if (act !== exp) begin
          errors++;
          $display("[TB] FAIL outputs@cycle%0d: got rdy=%b rd=%b/%h wr=%b/%h/%h rv=%b rdata=%h ill=%b, want rdy=%b rd=%b/%h wr=%b/%h/%h rv=%b rdata=%h ill=%b",
                   cyc, act.req_ready, act.rd_en, act.rd_addr, act.wr_en, act.wr_addr, act.wr_data,
                   act.resp_valid, act.rdata, act.illegal, exp.req_ready, exp.rd_en, exp.rd_addr,
                   exp.wr_en, exp.wr_addr, exp.wr_data, exp.resp_valid, exp.rdata, exp.illegal);
        end
      end
      if (act.rd_en) rd_count++;
      if (act.wr_en) begin
        wr_count++;
        last_wr_data = act.wr_data;
      end
      if (act.resp_valid) begin
        if (!prev_rv) last_resp_cyc = cyc;
        last_rdata   = act.rdata;
        last_illegal = act.illegal;
      end
      prev_rv = act.resp_valid;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
    instret_inc = (cyc <= inc_until);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Issue one request in the current (idle) cycle, derive the expected timeline from the
  // architectural rules, and hold resp_ready low for 'stall' response cycles.
  task automatic applyStimulus(input logic re, input logic we, input logic sel,
                               input logic [1:0] func, input logic [11:0] addr,
                               input logic [31:0] op, input logic [1:0] priv,
                               input int stall, input logic [31:0] ctr_old);
    int a;
    int r;
    logic ill;
    logic is_ctr;
    logic internal;
    logic [31:0] old;
    logic [31:0] nv;
    obs_t e;
    a        = cyc;
    ill      = (priv < addr[9:8]) || (we && (addr[11:10] == 2'b11));
    is_ctr   = COUNTERS && (addr inside {12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                         12'hC00, 12'hC80, 12'hC02, 12'hC82});
    internal = (addr == 12'hF14) || is_ctr;
    if (!re)                  old = '0;
    else if (addr == 12'hF14) old = HARTID;
    else if (is_ctr)          old = ctr_old;
    else                      old = mem_read(addr);
    case (func)
      F_RS:    nv = old | op;
      F_RC:    nv = old & ~op;
      default: nv = op;
    endcase
    e = '0;
    e.req_ready = 1'b1;
    sched[a] = e;
    if (ill) begin
      r = a + 1;
    end else begin
      e = '0;
      if (re && !internal) begin
        e.rd_en   = 1'b1;
        e.rd_addr = addr;
      end
      sched[a+1] = e;
      e = '0;
      if (we && (func != F_NONE) && !internal) begin
        e.wr_en   = 1'b1;
        e.wr_addr = addr;
        e.wr_data = nv;
      end
      sched[a+2] = e;
      r = a + 3;
    end
    e = '0;
    e.resp_valid = 1'b1;
    e.illegal    = ill;
    e.rdata      = ill ? 32'h0 : old;
    for (int k = 0; k <= stall; k++) sched[r+k] = e;

    req_valid   = 1'b1;
    req_params  = {re, we, sel, func, addr};
    req_operand = op;
    cur_priv    = priv;
    resp_ready  = (stall == 0);
    step();
    req_valid = 1'b0;
    while (cyc < r + stall) step();
    resp_ready = 1'b1;
    step();
  endtask

  initial begin
    int a;
    int rd0;
    int wr0;
    obs_t e;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_params  = '0;
    req_operand = '0;
    cur_priv    = P_M;
    resp_ready  = 1'b0;
    instret_inc = 1'b0;
    for (int k = 1; k <= 3; k++) sched[k] = '0;
    repeat (4) step();
    rst = 1'b0;
    $display("[TB] reset released at cycle %0d", cyc);

    // CSRRS 0x300 |= 0x8 on storage value 0x1800
    a = cyc;
    applyStimulus(1, 1, 0, F_RS, 12'h300, 32'h8, P_M, 0, 0);
    checkOutput("rs300_wdata", last_wr_data, 32'h1808);
    checkOutput("rs300_rdata", last_rdata, 32'h1800);
    checkOutput("rs300_latency", 32'(last_resp_cyc - a), 32'd3);

    // CSRRC with zero operand: read only
    rd0 = rd_count;
    wr0 = wr_count;
    applyStimulus(1, 0, 0, F_RC, 12'h300, 32'h0, P_M, 0, 0);
    checkOutput("rc300_rdata", last_rdata, 32'h1808);
    checkOutput("rc300_rd_strobes", 32'(rd_count - rd0), 32'd1);
    checkOutput("rc300_wr_strobes", 32'(wr_count - wr0), 32'd0);

    // User-mode access to a machine CSR
    rd0 = rd_count;
    wr0 = wr_count;
    a   = cyc;
    applyStimulus(1, 1, 0, F_RW, 12'h341, 32'h1, P_U, 0, 0);
    checkOutput("priv_illegal_flag", {31'd0, last_illegal}, 32'd1);
    checkOutput("priv_illegal_latency", 32'(last_resp_cyc - a), 32'd1);
    checkOutput("priv_illegal_rdata", last_rdata, 32'h0);
    checkOutput("priv_illegal_strobes", 32'((rd_count - rd0) + (wr_count - wr0)), 32'd0);

    // Write to a read-only CSR, and privilege boundary around 0x200
    applyStimulus(1, 1, 0, F_RW, 12'hC00, 32'h1, P_M, 0, 0);
    checkOutput("ro_write_illegal", {31'd0, last_illegal}, 32'd1);
    applyStimulus(1, 0, 0, F_RS, 12'h200, 32'h0, P_S, 0, 0);
    checkOutput("s_below_h_illegal", {31'd0, last_illegal}, 32'd1);
    applyStimulus(1, 0, 0, F_RS, 12'h200, 32'h0, 2'd2, 0, 0);
    checkOutput("h_equal_legal_rdata", last_rdata, 32'h8000_2000);

    // CSRRW then CSRRC with a 5-cycle response stall
    applyStimulus(1, 1, 0, F_RW, 12'h341, 32'h8000_1000, P_M, 0, 0);
    checkOutput("rw341_rdata", last_rdata, 32'h8000_3410);
    applyStimulus(1, 1, 0, F_RC, 12'h341, 32'h0000_1000, P_M, 5, 0);
    checkOutput("rc341_wdata", last_wr_data, 32'h8000_0000);
    checkOutput("rc341_stall_rdata", last_rdata, 32'h8000_1000);

    // mhartid served internally
    rd0 = rd_count;
    applyStimulus(1, 0, 0, F_RS, 12'hF14, 32'h0, P_M, 0, 0);
    checkOutput("mhartid_rdata", last_rdata, 32'd7);
    checkOutput("mhartid_no_rd", 32'(rd_count - rd0), 32'd0);

    // Write without read: old is zero
    applyStimulus(0, 1, 0, F_RW, 12'h340, 32'h0000_1234, P_M, 0, 0);
    checkOutput("noread_rdata", last_rdata, 32'h0);
    checkOutput("noread_wdata", last_wr_data, 32'h0000_1234);

    // Reset during WRITE abandons the request
    a   = cyc;
    wr0 = wr_count;
    e = '0;
    e.req_ready = 1'b1;
    sched[a]   = e;
    sched[a+3] = e;
    sched[a+2] = '0;
    e = '0;
    e.rd_en   = 1'b1;
    e.rd_addr = 12'h340;
    sched[a+1] = e;
    req_valid   = 1'b1;
    req_params  = {1'b1, 1'b1, 1'b0, F_RW, 12'h340};
    req_operand = 32'h0000_DEAD;
    cur_priv    = P_M;
    resp_ready  = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("reset_no_write", 32'(wr_count - wr0), 32'd0);
    checkOutput("reset_mem_kept", mem_read(12'h340), 32'h0000_1234);

`ifdef CSR_COUNTERS_EN
    wr0 = wr_count;
    applyStimulus(0, 1, 0, F_RW, 12'hB00, 32'hFFFF_FFFF, P_M, 0, 0);
    checkOutput("mcycle_wr_no_storage", 32'(wr_count - wr0), 32'd0);
    applyStimulus(1, 0, 0, F_RS, 12'hB80, 32'h0, P_M, 0, 32'd1);
    checkOutput("mcycle_carry", last_rdata, 32'd1);
    inc_until   = cyc + 2;
    instret_inc = 1'b1;
    applyStimulus(0, 1, 0, F_RW, 12'hB02, 32'h50, P_M, 0, 0);
    applyStimulus(1, 0, 0, F_RS, 12'hC02, 32'h0, P_M, 0, 32'h50);
    checkOutput("minstret_write_priority", last_rdata, 32'h50);
`else
    inc_until   = cyc + 4;
    instret_inc = 1'b1;
    applyStimulus(1, 1, 0, F_RW, 12'hB00, 32'h55, P_M, 0, 0);
    checkOutput("b00_storage_rdata", last_rdata, 32'h8000_B000);
    checkOutput("b00_storage_wdata", last_wr_data, 32'h55);
    applyStimulus(1, 0, 0, F_RS, 12'hC00, 32'h0, P_M, 0, 0);
    checkOutput("c00_storage_rdata", last_rdata, 32'h8000_C000);
`endif

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_access_ctrl.md
CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width of CSR values and operands.
REQ-002 SHALL have parameter MHARTID_VAL, default 0, meaning the value returned for CSR 0xF14 (served internally, read-only).
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-005 SHALL have port req_valid, input, 1: a CSR instruction is offered.
REQ-006 SHALL have port req_ready, output, 1: the controller accepts on req_valid&&req_ready.
REQ-007 SHALL have port req_params, input, 17: csr_params_t, packed as {read_enable, write_enable, input_select, write_func[1:0], addr[11:0]}.
REQ-008 SHALL have port req_operand, input, XLEN: RS1 value, or zero-extended 5-bit uimm.
REQ-009 SHALL have port cur_priv, input, 2: current privilege, encoded as csr_addr_priv.
REQ-010 SHALL have port csr_rd_en / csr_rd_addr / csr_rd_data, output / output / input, 1/12/XLEN: storage read port, data valid exactly 1 cycle after csr_rd_en.
REQ-011 SHALL have port csr_wr_en / csr_wr_addr / csr_wr_data, output / output / output, 1/12/XLEN: storage write port.
REQ-012 SHALL have port instret_inc, input, 1: one instruction retired this cycle.
REQ-013 SHALL have port resp_valid / resp_ready / resp_rdata / resp_illegal, output / input / output / output, 1/1/XLEN/1: response handshake.

Function
REQ-014 SHALL implement FSM states IDLE, READ, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 On acceptance, SHALL latch params, operand and cur_priv, then go to READ.
- Exception: an illegal request goes directly to RESP with resp_illegal=1.
- A request is illegal when cur_priv < addr[9:8], or when write_enable=1 and addr[11:10]=2'b11.
REQ-016 An illegal request SHALL assert neither csr_rd_en nor csr_wr_en.
REQ-017 READ: SHALL assert csr_rd_en for one cycle with the latched addr iff read_enable=1 and the addr is not internally served; then go to WRITE.
REQ-018 WRITE: SHALL capture the read data as old, then compute new:
- RW: new = operand.
- RS: new = old | operand.
- RC: new = old & ~operand.
- NONE: no write.
REQ-019 WRITE: SHALL assert csr_wr_en for one cycle iff write_enable=1 and write_func!=NONE; then go to RESP.
REQ-020 When read_enable=0, old SHALL be treated as 0 for RW, and resp_rdata SHALL be 0.
REQ-021 RESP: SHALL hold resp_valid=1 with resp_rdata=old (0 if illegal) stable until resp_ready; then go to IDLE.
REQ-022 SHALL deliver legal requests with resp_valid first high 3 cycles after the acceptance edge, and illegal requests 1 cycle after it.
REQ-023 Back-to-back throughput SHALL be one request per 4 cycles when resp_ready is held at 1.
REQ-024 Reads of 0xF14 SHALL return MHARTID_VAL without a storage access.
REQ-025 The storage ports SHALL never be active outside READ/WRITE.

Reset
REQ-026 While rst=1, SHALL force state=IDLE and hold these outputs at 0: req_ready, resp_valid, resp_illegal, resp_rdata, csr_rd_en, csr_wr_en, csr_rd_addr, csr_wr_addr, csr_wr_data. The counters SHALL also clear to 0.
REQ-027 rst asserted mid-operation SHALL abandon the request with no write issued after the reset edge; req_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-028 With CSR_COUNTERS_EN defined, SHALL implement internal 64-bit mcycle and minstret:
- mcycle increments every non-reset cycle.
- minstret increments when instret_inc=1.
REQ-029 Under CSR_COUNTERS_EN, the counters SHALL be served internally:
- 0xB00/0xB80/0xB02/0xB82 are read/write, low/high halves.
- 0xC00/0xC80/0xC02/0xC82 are read-only aliases.
- These accesses never touch the storage port.
- A CSR write coinciding with an increment SHALL take priority (written value loaded, no increment that cycle).
REQ-030 Without CSR_COUNTERS_EN, there SHALL be no counters: instret_inc is ignored and all counter addresses go to the storage port like any other CSR.

Verification
REQ-031 CSRRS to 0x300 (M-mode), operand 0x8, storage returns 0x1800 -> csr_wr_data=0x1808 and resp_rdata=0x1800, resp_valid 3 cycles after acceptance.
REQ-032 CSRRC to 0x300 with operand 0 (write_enable=0) -> csr_rd_en pulses, csr_wr_en never asserts, resp_rdata equals the read data.
REQ-033 CSRRW to 0x341 from cur_priv=USER -> resp_illegal=1 after 1 cycle, no rd/wr strobes, resp_rdata=0.
REQ-034 CSRRW to 0xC00 (read-only) from M-mode -> resp_illegal=1.
REQ-035 resp_ready held at 0 for 5 cycles -> resp_valid/resp_rdata stable and req_ready stays 0; rst pulse during WRITE -> no csr_wr_en, IDLE next.
REQ-036 CSR_COUNTERS_EN: write 0xFFFFFFFF to 0xB00, then read 0xB80 two cycles later -> high half = 1 (carry); same-cycle write plus increment -> written value kept.
